spi_sd_frame_receiver: RTL



---
 rtl/spi_sd_frame_receiver_pkg.sv | 30 +++
 rtl/spi_sck_sampler.sv | 40 ++++
 rtl/spi_sd_frame_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_sd_frame_receiver_pkg.sv
// Shared definitions for the SD-style SPI frame receiver: FSM encoding, start token,
// CRC7 polynomial and step function, and frame-length derivation.
package spi_sd_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_TRANS = 4'd1;
  localparam logic [3:0] ST_CMD   = 4'd2;
  localparam logic [3:0] ST_ARG   = 4'd3;
  localparam logic [3:0] ST_CRC   = 4'd4;
  localparam logic [3:0] ST_ENDB  = 4'd5;
  localparam logic [3:0] ST_TOKEN = 4'd6;
  localparam logic [3:0] ST_DATA  = 4'd7;
  localparam logic [3:0] ST_DCRC  = 4'd8;

  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam int         CRC_W       = 7;

  // Start + transmission + command + argument + CRC7 + end bit.
  function automatic int frame_bits(input int cmd_w, input int arg_w);
    return 2 + cmd_w + arg_w + CRC_W + 1;
  endfunction

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/spi_sck_sampler.sv
// Synchronises SCK/MOSI/CS_n into the system clock and flags each SCK rising edge
// seen while chip select is active.
module spi_sck_sampler (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  input  logic cs_n,
  output logic bit_valid,
  output logic bit_value,
  output logic cs_active
);

  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync <= 2'b00;
      cs_sync  <= 2'b11;
      sck_q    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      cs_sync  <= {cs_sync[0], cs_n};
      sck_q    <= sck_sync[1];
    end
  end

  always_ff @(posedge clock) begin
    mosi_sync <= {mosi_sync[0], mosi};
  end

  // CS_n shares the SCK pipeline depth, so a deselect masks a coincident edge.
  assign cs_active = ~cs_sync[1];
  assign bit_valid = sck_sync[1] & ~sck_q & cs_active;
  assign bit_value = mosi_sync[1];

endmodule

// File: rtl/spi_sd_frame_receiver.sv
// SD-style SPI slave frame receiver: command frames plus optional token-framed data block.
// Define SPI_CRC_CHECK_EN to reject frames whose CRC7 does not match.
module spi_sd_frame_receiver
  import spi_sd_pkg::*;
#(
  parameter int CMD_W         = 6,
  parameter int ARG_W         = 32,
  parameter int MAX_BLOCK     = 512,
  parameter int TOKEN_TIMEOUT = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_Sck,
  input  logic                           io_Mosi,
  input  logic                           io_Cs_n,
  input  logic                           io_ExpectData,
  input  logic [$clog2(MAX_BLOCK+1)-1:0] io_DataBlockSize,
  output logic                           io_CommandValid,
  output logic [CMD_W-1:0]               io_Command,
  output logic [ARG_W-1:0]               io_CommandArgument,
  output logic                           io_FrameError,
  output logic                           io_DataValid,
  output logic [7:0]                     io_Data,
  output logic                           io_DataLast,
  output logic                           io_TokenTimeout
);

  localparam int BS_W  = $clog2(MAX_BLOCK + 1);
  localparam int CNT_W = $clog2(frame_bits(CMD_W, ARG_W));
  localparam int TMO_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [BS_W-1:0] MAX_BS = BS_W'(MAX_BLOCK);

  logic             bit_valid;
  logic             bit_value;
  logic             cs_active;
  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bcnt;
  logic [TMO_W-1:0] tmo;
  logic [BS_W-1:0]  byte_cnt;
  logic [BS_W-1:0]  blk_last;
  logic [BS_W-1:0]  eff_size;
  logic [CMD_W-1:0] cmd_sr;
  logic [ARG_W-1:0] arg_sr;
  logic [6:0]       byte_sr;
  logic [7:0]       byte_next;
  logic             byte_done;
  logic             crc_ok;

  spi_sck_sampler u_sampler (
    .clock     (clock),
    .reset     (reset),
    .sck       (io_Sck),
    .mosi      (io_Mosi),
    .cs_n      (io_Cs_n),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .cs_active (cs_active)
  );

  assign byte_next = {byte_sr, bit_value};
  assign byte_done = (bcnt == 3'd7);

  always_comb begin
    eff_size = io_DataBlockSize;
    if (io_DataBlockSize == '0 || io_DataBlockSize > MAX_BS) eff_size = MAX_BS;
  end

  always_ff @(posedge clock) begin
    if (bit_valid) begin
      case (state)
        ST_CMD:                    cmd_sr  <= {cmd_sr[CMD_W-2:0], bit_value};
        ST_ARG:                    arg_sr  <= {arg_sr[ARG_W-2:0], bit_value};
        ST_TOKEN, ST_DATA, ST_DCRC: byte_sr <= byte_next[6:0];
        default: ;
      endcase
    end
  end

`ifdef SPI_CRC_CHECK_EN
  logic [6:0] crc_calc;
  logic [6:0] crc_rx;

  // CRC restarts on every (re)start bit and covers start, transmission, command and argument.
  always_ff @(posedge clock) begin
    if (bit_valid) begin
      case (state)
        ST_IDLE:        crc_calc <= 7'h00;
        ST_TRANS:       crc_calc <= bit_value ? crc7_step(7'h00, 1'b0) ^ crc7_step(7'h00, 1'b1)
                                              : 7'h00;
        ST_CMD, ST_ARG: crc_calc <= crc7_step(crc_calc, bit_value);
        ST_CRC:         crc_rx   <= {crc_rx[5:0], bit_value};
        default: ;
      endcase
    end
  end

  assign crc_ok = (crc_rx == crc_calc);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      bcnt               <= '0;
      tmo                <= '0;
      byte_cnt           <= '0;
      blk_last           <= '0;
      io_CommandValid    <= 1'b0;
      io_Command         <= '0;
      io_CommandArgument <= '0;
      io_FrameError      <= 1'b0;
      io_DataValid       <= 1'b0;
      io_Data            <= '0;
      io_DataLast        <= 1'b0;
      io_TokenTimeout    <= 1'b0;
    end else begin
      io_CommandValid <= 1'b0;
      io_FrameError   <= 1'b0;
      io_DataValid    <= 1'b0;
      io_DataLast     <= 1'b0;
      io_TokenTimeout <= 1'b0;
      if (!cs_active) begin
        state <= ST_IDLE;
      end else if (io_CommandValid && state == ST_TOKEN && !io_ExpectData) begin
        // The controller answers io_ExpectData during the accept pulse.
        state <= ST_IDLE;
      end else if (bit_valid) begin
        case (state)
          ST_IDLE: if (!bit_value) state <= ST_TRANS;
          ST_TRANS: begin
            if (bit_value) begin
              state <= ST_CMD;
              cnt   <= '0;
            end
          end
          ST_CMD: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMD_W - 1)) begin
              state <= ST_ARG;
              cnt   <= '0;
            end
          end
          ST_ARG: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ARG_W - 1)) begin
              state <= ST_CRC;
              cnt   <= '0;
            end
          end
          ST_CRC: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CRC_W - 1)) begin
              state <= ST_ENDB;
              cnt   <= '0;
            end
          end
          ST_ENDB: begin
            if (bit_value && crc_ok) begin
              io_CommandValid    <= 1'b1;
              io_Command         <= cmd_sr;
              io_CommandArgument <= arg_sr;
              state              <= ST_TOKEN;
              bcnt               <= '0;
              tmo                <= '0;
            end else begin
              io_FrameError <= 1'b1;
              state         <= ST_IDLE;
            end
          end
          ST_TOKEN: begin
            bcnt <= bcnt + 3'd1;
            if (byte_done) begin
              if (byte_next == START_TOKEN) begin
                state    <= ST_DATA;
                byte_cnt <= '0;
                blk_last <= eff_size - BS_W'(1);
              end else if (tmo == TMO_W'(TOKEN_TIMEOUT - 1)) begin
                io_TokenTimeout <= 1'b1;
                state           <= ST_IDLE;
              end else begin
                tmo <= tmo + TMO_W'(1);
              end
            end
          end
          ST_DATA: begin
            bcnt <= bcnt + 3'd1;
            if (byte_done) begin
              io_DataValid <= 1'b1;
              io_Data      <= byte_next;
              byte_cnt     <= byte_cnt + BS_W'(1);
              if (byte_cnt == blk_last) begin
                io_DataLast <= 1'b1;
                state       <= ST_DCRC;
                byte_cnt    <= '0;
              end
            end
          end
          ST_DCRC: begin
            bcnt <= bcnt + 3'd1;
            if (byte_done) begin
              byte_cnt <= byte_cnt + BS_W'(1);
              if (byte_cnt == BS_W'(1)) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
